// File: rtl/dibit_pkg.sv
// rtl/dibit_pkg.sv - shared types and constants for the dibit serializer
//
// Purpose : state encoding and lane geometry used by dibit_serializer.
// Contents: DIBITS_PER_WORD (lanes per byte), DIBIT_W (lane width),
//           state_t (IDLE = shifter empty, SHIFT = shifter holds a word).
package dibit_pkg;

    localparam int DIBITS_PER_WORD = 4;
    localparam int DIBIT_W         = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/dibit_serializer.sv
// rtl/dibit_serializer.sv - byte to 2-bit lane serializer with one-word holding buffer
//
// Purpose : accepts bytes on a valid/ready input, optionally nibble-swapped,
//           and emits them as four 2-bit lanes on a valid/ready output.
//           A shift register holds the active word; a single holding
//           buffer lets the next word queue up so words stream back to
//           back without a bubble.
// Params  : MSB_FIRST - 0: lane 0 is word[1:0]; 1: lane 0 is word[7:6].
// Ports   : clk, rst_n (async, active-low)
//           in_valid/in_ready/in_data/in_swap - input word handshake
//           in_flush   - synchronous discard of shifter and buffer
//           out_valid/out_ready/out_dibit      - output lane handshake
//           out_first/out_last - current lane is index 0 / index 3
//           words_sent - count of fully transmitted words (wraps)
module dibit_serializer
    import dibit_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_swap,
    input  logic               in_flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIBIT_W-1:0] out_dibit,
    output logic               out_first,
    output logic               out_last,
    output logic [7:0]         words_sent
);

    localparam logic [1:0] LAST_IDX = 2'(DIBITS_PER_WORD - 1);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic [1:0] idx_q, idx_d;
    logic       in_ready_q;
    logic [7:0] words_q, words_d;

    logic       accept;
    logic       xfer;
    logic       last_xfer;
    logic [7:0] in_word;
    logic [7:0] shifted;

    assign out_valid = (state_q == SHIFT);
    assign accept    = in_valid && in_ready_q;
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);
    assign in_word   = in_swap ? {in_data[3:0], in_data[7:4]} : in_data;

    // The outgoing lane always sits at one end of the shifter, so each
    // transfer moves the next lane into that position.
    assign shifted = MSB_FIRST ? {shreg_q[7-DIBIT_W:0], {DIBIT_W{1'b0}}}
                               : {{DIBIT_W{1'b0}}, shreg_q[7:DIBIT_W]};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        idx_d      = idx_q;
        words_d    = words_q;
        if (in_flush) begin
            state_d    = IDLE;
            shreg_d    = '0;
            buf_full_d = 1'b0;
            idx_d      = '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                state_d = SHIFT;
                shreg_d = in_word;
                idx_d   = '0;
            end
        end else if (last_xfer) begin
            idx_d   = '0;
            words_d = words_q + 8'd1;
            // in_ready is low whenever the buffer is full, so a same-cycle
            // accept can only coincide with an empty buffer.
            if (buf_full_q) begin
                shreg_d    = buf_q;
                buf_full_d = 1'b0;
            end else if (accept) begin
                shreg_d = in_word;
            end else begin
                state_d = IDLE;
                shreg_d = '0;
            end
        end else begin
            if (xfer) begin
                idx_d   = idx_q + 2'd1;
                shreg_d = shifted;
            end
            if (accept) begin
                buf_d      = in_word;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            idx_q      <= idx_d;
            // Registered copy of the next buffer state keeps in_ready free
            // of any combinational path from in_valid or out_ready.
            in_ready_q <= !buf_full_d;
            words_q    <= words_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_dibit  = out_valid ? (MSB_FIRST ? shreg_q[7:8-DIBIT_W] : shreg_q[DIBIT_W-1:0])
                                  : '0;
    assign out_first  = out_valid && (idx_q == 2'd0);
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign words_sent = words_q;

endmodule

// File: doc/dibit_serializer.md
DIBIT_SERIALIZER -- requirements
Module: dibit_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 0: 0 = dibit 0 is word[1:0]; 1 = dibit 0 is word[7:6].
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_data/in_swap valid.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  8  byte to serialize.
REQ-007 in_swap  input  1  swap nibbles of in_data at acceptance.
REQ-008 in_flush  input  1  synchronous discard of all held data.
REQ-009 out_valid  output  1  out_dibit valid.
REQ-010 out_ready  input  1  sink takes out_dibit this cycle.
REQ-011 out_dibit  output  2  current 2-bit lane.
REQ-012 out_first  output  1  current dibit is index 0 of its word.
REQ-013 out_last  output  1  current dibit is index 3 of its word.
REQ-014 words_sent  output  8  count of fully transmitted words, wraps.

Function
REQ-015 Accept occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 Accepted word = in_swap ? {in_data[3:0], in_data[7:4]} : in_data, captured on the accept edge.
REQ-017 Storage: one shift register (active word) and one holding buffer; in_ready = !buf_full, registered, with no combinational path from out_ready or in_valid.
REQ-018 States: IDLE (shifter empty, out_valid=0) and SHIFT (shifter loaded, out_valid=1); 2-bit index counter 0..3.
REQ-019 IDLE with accept: word loads directly into shifter, bypassing the buffer; out_valid=1, index=0 on the next cycle (latency 1).
REQ-020 SHIFT with accept: word goes into the buffer; buf_full=1.
REQ-021 Transfer with index<3: index increments; out_dibit advances to the next lane next cycle.
REQ-022 Transfer with index=3: index wraps to 0; words_sent increments modulo 256 (255 -> 0); shifter reloads from the buffer if buf_full (buffer empties), else from a same-cycle accept, else the block goes to IDLE.
REQ-023 Consecutive words with the buffer filled in time: one dibit per cycle, no bubble between words.
REQ-024 Stall: while out_valid && !out_ready, out_dibit, out_first, out_last and index hold stable.
REQ-025 out_first = (index==0) && out_valid; out_last = (index==3) && out_valid.
REQ-026 in_flush: next cycle shifter and buffer empty, state IDLE, out_valid=0, in_ready=1, words_sent unchanged; any same-cycle accept or transfer is discarded and not counted.
REQ-027 Lane order: lane k = word[2k+1:2k] when MSB_FIRST=0, word[7-2k:6-2k] when MSB_FIRST=1.

Reset
REQ-028 rst_n low: out_valid=0, out_dibit=0, out_first=0, out_last=0, words_sent=0, in_ready=0, buffer empty, state IDLE, index=0, all immediately.
REQ-029 in_ready rises on the first clk edge after rst_n deassertion.
REQ-030 Reset mid-word drops the partial word; words_sent does not count it.

Structure
REQ-031 Package dibit_pkg holds the state typedef (IDLE, SHIFT), DIBITS_PER_WORD=4 and DIBIT_W=2.
REQ-032 Single module, no sub-module; the holding buffer is inline.

Verification
REQ-033 MSB_FIRST=0, in_data=8'hB4, in_swap=0, out_ready=1 -> dibits 0,1,3,2 on cycles 1-4; out_first on cycle 1; out_last on cycle 4; words_sent=1.
REQ-034 Same stimulus with in_swap=1 (word 8'h4B) -> dibits 3,2,0,1.
REQ-035 in_valid held high with 8'h00 then 8'hFF, out_ready=1 -> 8 consecutive dibits 0,0,0,0,3,3,3,3 with no bubble; in_ready=0 while the buffer is full.
REQ-036 out_ready=0 for 5 cycles after the first dibit of 8'hB4 -> out_dibit=1 stays stable with out_valid=1 throughout; the sequence resumes on release.
REQ-037 in_flush after 2 transfers with the buffer full -> next cycle out_valid=0, in_ready=1, words_sent unchanged; rst_n pulse mid-word -> all outputs 0 without waiting for a clock edge.
REQ-038 256 words sent back-to-back -> words_sent wraps to 0 after the last dibit of word 256.
